// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
//
// Scans a 4x4 matrix hex keypad. One row is driven low at a time. The column
// inputs are synchronised, then sampled once per row dwell period ("tick").
// Each press and each release must be seen on DEB_COUNT consecutive ticks
// before it is accepted. An accepted key is presented as a 4-bit hex code
// through a one-entry holding register with a valid/ack handshake.
//
// Parameters
//   DWELL_BITS  Row dwell is 2**DWELL_BITS clk cycles.
//   DEB_COUNT   Consecutive identical samples needed for a press or a
//               release (2..15).
//
// Ports
//   clk          in   System clock, rising edge.
//   clear        in   Synchronous active-low reset.
//   col[3:0]     in   Keypad columns, active-low, asynchronous.
//   row[3:0]     out  Keypad row drive, active-low, exactly one bit low.
//   key_code[3:0]out  Hex code of the last accepted key.
//   key_valid    out  key_code holds a key the consumer has not acknowledged.
//   key_ack      in   Consumer acknowledge.
//   key_down     out  The accepted key is still held down.
//   overrun      out  Sticky: an unacknowledged key was overwritten.
//   dbg_state_o  out  Current scanner state (SCAN/DEBOUNCE/HELD).
//
// Handshake: key_valid rises on the edge that commits a key. A key_ack seen
// while key_valid=1 drops key_valid on the next edge; key_ack with
// key_valid=0 has no effect. If a commit and an ack land on the same edge the
// new key wins: key_valid stays 1 and overrun is not touched. A commit while
// key_valid=1 without an ack overwrites key_code and sets overrun.
// -----------------------------------------------------------------------------
module keypad_scanner #(
    parameter int unsigned DWELL_BITS = 16,
    parameter int unsigned DEB_COUNT  = 4
) (
    input  logic       clk,
    input  logic       clear,
    input  logic [3:0] col,
    output logic [3:0] row,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ack,
    output logic       key_down,
    output logic       overrun,
    output logic [1:0] dbg_state_o
);

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2
    } state_e;

    localparam logic [3:0]            DEB_LIM   = 4'(DEB_COUNT);
    localparam logic [DWELL_BITS-1:0] DWELL_ONE = DWELL_BITS'(1);

    logic [3:0]            col_s1_q, col_s2_q;
    logic [DWELL_BITS-1:0] dwell_q;
    state_e                state_q, state_d;
    logic [1:0]            ridx_q, ridx_d;
    logic [1:0]            csel_q, csel_d;
    logic [3:0]            pcnt_q, pcnt_d;
    logic [3:0]            rcnt_q, rcnt_d;
    logic [3:0]            key_code_q, key_code_d;
    logic                  valid_q, valid_d;
    logic                  overrun_q, overrun_d;

    logic       tick;
    logic       any_low;
    logic [1:0] low_idx;
    logic       lat_low;
    logic       commit;
    logic [3:0] hex_code;

    assign tick    = &dwell_q;
    assign lat_low = ~col_s2_q[csel_q];

    // Lowest-numbered low column wins: scan downwards so the last hit is
    // the smallest index.
    always_comb begin
        low_idx = 2'd0;
        any_low = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (!col_s2_q[i]) begin
                low_idx = 2'(i);
                any_low = 1'b1;
            end
        end
    end

    // Key map indexed by {row, column}.
    always_comb begin
        hex_code = 4'h0;
        case ({ridx_q, csel_q})
            4'b00_00: hex_code = 4'h1;
            4'b00_01: hex_code = 4'h2;
            4'b00_10: hex_code = 4'h3;
            4'b00_11: hex_code = 4'hA;
            4'b01_00: hex_code = 4'h4;
            4'b01_01: hex_code = 4'h5;
            4'b01_10: hex_code = 4'h6;
            4'b01_11: hex_code = 4'hB;
            4'b10_00: hex_code = 4'h7;
            4'b10_01: hex_code = 4'h8;
            4'b10_10: hex_code = 4'h9;
            4'b10_11: hex_code = 4'hC;
            4'b11_00: hex_code = 4'h0;
            4'b11_01: hex_code = 4'hF;
            4'b11_10: hex_code = 4'hE;
            4'b11_11: hex_code = 4'hD;
            default:  hex_code = 4'h0;
        endcase
    end

    // Scanner FSM. Everything advances only on tick; ridx stays frozen while
    // a key is being debounced or held so csel keeps pointing at the same key.
    always_comb begin
        state_d = state_q;
        ridx_d  = ridx_q;
        csel_d  = csel_q;
        pcnt_d  = pcnt_q;
        rcnt_d  = rcnt_q;
        commit  = 1'b0;
        if (tick) begin
            case (state_q)
                ST_SCAN: begin
                    if (any_low) begin
                        csel_d  = low_idx;
                        pcnt_d  = 4'd1;
                        state_d = ST_DEBOUNCE;
                    end else begin
                        ridx_d = ridx_q + 2'd1;
                    end
                end
                ST_DEBOUNCE: begin
                    if (lat_low) begin
                        pcnt_d = pcnt_q + 4'd1;
                        if (pcnt_q + 4'd1 == DEB_LIM) begin
                            commit  = 1'b1;
                            rcnt_d  = 4'd0;
                            state_d = ST_HELD;
                        end
                    end else begin
                        state_d = ST_SCAN;
                        ridx_d  = ridx_q + 2'd1;
                    end
                end
                ST_HELD: begin
                    if (!lat_low) begin
                        rcnt_d = rcnt_q + 4'd1;
                        if (rcnt_q + 4'd1 == DEB_LIM) begin
                            state_d = ST_SCAN;
                            ridx_d  = ridx_q + 2'd1;
                        end
                    end else begin
                        rcnt_d = 4'd0;
                    end
                end
                default: state_d = ST_SCAN;
            endcase
        end
    end

    // Holding register. A commit takes priority over an ack.
    always_comb begin
        key_code_d = key_code_q;
        valid_d    = valid_q;
        overrun_d  = overrun_q;
        if (commit) begin
            key_code_d = hex_code;
            valid_d    = 1'b1;
            if (valid_q && !key_ack) overrun_d = 1'b1;
        end else if (key_ack) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!clear) begin
            col_s1_q   <= 4'hF;
            col_s2_q   <= 4'hF;
            dwell_q    <= '0;
            state_q    <= ST_SCAN;
            ridx_q     <= 2'd0;
            csel_q     <= 2'd0;
            pcnt_q     <= 4'd0;
            rcnt_q     <= 4'd0;
            key_code_q <= 4'h0;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            col_s1_q   <= col;
            col_s2_q   <= col_s1_q;
            dwell_q    <= dwell_q + DWELL_ONE;
            state_q    <= state_d;
            ridx_q     <= ridx_d;
            csel_q     <= csel_d;
            pcnt_q     <= pcnt_d;
            rcnt_q     <= rcnt_d;
            key_code_q <= key_code_d;
            valid_q    <= valid_d;
            overrun_q  <= overrun_d;
        end
    end

    assign row         = ~(4'b0001 << ridx_q);
    assign key_code    = key_code_q;
    assign key_valid   = valid_q;
    assign key_down    = (state_q == ST_HELD);
    assign overrun     = overrun_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// -----------------------------------------------------------------------------
// tb_keypad_scanner
//
// Drives keypad_scanner (DWELL_BITS=4, DEB_COUNT=3) from an emulated key
// matrix: a column reads low when a pressed key sits on the row currently
// driven low. A tick-level behavioural model predicts row, key_down,
// key_valid, key_code and overrun after every dwell period.
// -----------------------------------------------------------------------------
module tb_keypad_scanner;

    localparam int DW   = 4;
    localparam int DEB  = 3;
    localparam int PER  = 1 << DW;

    logic       clk = 1'b0;
    logic       clear;
    logic [3:0] col;
    logic [3:0] row;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ack;
    logic       key_down;
    logic       overrun;
    logic [1:0] dbg_state;

    always #5 clk = ~clk;

    keypad_scanner #(.DWELL_BITS(DW), .DEB_COUNT(DEB)) dut (
        .clk        (clk),
        .clear      (clear),
        .col        (col),
        .row        (row),
        .key_code   (key_code),
        .key_valid  (key_valid),
        .key_ack    (key_ack),
        .key_down   (key_down),
        .overrun    (overrun),
        .dbg_state_o(dbg_state)
    );

    int checks = 0;
    int errors = 0;

    // Physical keypad: pressed[r][c].
    bit         pressed[4][4];
    logic [3:0] keymap[16];

    // Behavioural model, one step per tick.
    // m_mode: 0 idle scanning, 1 press being confirmed, 2 key held.
    int         m_row, m_mode, m_cnt, m_col;
    bit         m_valid, m_over;
    logic [3:0] m_code;
    logic [3:0] exp_q[$];   // codes the model expects the DUT to commit

    int         valid_rises = 0;
    logic       valid_prev  = 1'b0;

    always @(negedge clk) begin
        if (key_valid === 1'b1 && valid_prev !== 1'b1) valid_rises++;
        valid_prev = key_valid;
    end

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] pad_cols(input logic [3:0] r);
        logic [3:0] c;
        c = 4'hF;
        for (int ri = 0; ri < 4; ri++)
            if (r[ri] === 1'b0)
                for (int ci = 0; ci < 4; ci++)
                    if (pressed[ri][ci]) c[ci] = 1'b0;
        return c;
    endfunction

    function automatic int low_col(input int r);
        for (int ci = 0; ci < 4; ci++)
            if (pressed[r][ci]) return ci;
        return -1;
    endfunction

    function automatic bit would_commit();
        return (m_mode == 1) && (m_cnt == DEB - 1) && pressed[m_row][m_col];
    endfunction

    task automatic release_all();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                pressed[r][c] = 1'b0;
    endtask

    task automatic model_reset();
        m_row = 0; m_mode = 0; m_cnt = 0; m_col = 0;
        m_valid = 1'b0; m_over = 1'b0; m_code = 4'h0;
        exp_q.delete();
    endtask

    task automatic model_tick(input bit ack_on_tick);
        bit got;
        int c;
        got = 1'b0;
        if (m_mode == 0) begin
            c = low_col(m_row);
            if (c < 0) m_row = (m_row + 1) % 4;
            else begin m_mode = 1; m_col = c; m_cnt = 1; end
        end else if (m_mode == 1) begin
            if (pressed[m_row][m_col]) begin
                m_cnt++;
                if (m_cnt == DEB) begin got = 1'b1; m_mode = 2; m_cnt = 0; end
            end else begin
                m_mode = 0; m_row = (m_row + 1) % 4;
            end
        end else begin
            if (!pressed[m_row][m_col]) begin
                m_cnt++;
                if (m_cnt == DEB) begin m_mode = 0; m_row = (m_row + 1) % 4; end
            end else begin
                m_cnt = 0;
            end
        end
        if (got) begin
            if (m_valid && !ack_on_tick) m_over = 1'b1;
            m_valid = 1'b1;
            m_code  = keymap[m_row * 4 + m_col];
            exp_q.push_back(m_code);
        end else if (ack_on_tick) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic check_outputs();
        logic [3:0] exp_row;
        exp_row = 4'hF;
        exp_row[m_row] = 1'b0;
        check("row", row, exp_row);
        check("key_down", {3'b0, key_down}, {3'b0, m_mode == 2});
        check("key_valid", {3'b0, key_valid}, {3'b0, m_valid});
        check("overrun", {3'b0, overrun}, {3'b0, m_over});
        check("key_code", key_code, m_code);
        if (exp_q.size() > 0) check("commit_code", key_code, exp_q.pop_front());
    endtask

    // One dwell period. ack_at is the cycle (0..PER-1) in which key_ack is
    // pulsed, or -1 for none; PER-1 is the tick cycle itself.
    task automatic run_period(input int ack_at);
        for (int j = 0; j < PER; j++) begin
            @(negedge clk);
            col     = pad_cols(row);
            key_ack = (j == ack_at);
            if (j == ack_at && j != PER - 1) m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        key_ack = 1'b0;
        model_tick(ack_at == PER - 1);
        check_outputs();
    endtask

    task automatic run_periods(input int n);
        for (int k = 0; k < n; k++) run_period(-1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear   = 1'b0;
        key_ack = 1'b0;
        @(posedge clk);
        #1;
        clear = 1'b1;
        model_reset();
    endtask

    initial begin
        int base, n, hold, gap, a, r1, c1, r2, c2;
        keymap = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                   4'h7, 4'h8, 4'h9, 4'hC, 4'h0, 4'hF, 4'hE, 4'hD};
        clear   = 1'b0;
        key_ack = 1'b0;
        col     = 4'hF;
        release_all();

        // Reset values
        do_reset();
        check("rst_row", row, 4'b1110);
        check("rst_code", key_code, 4'h0);
        check("rst_valid", {3'b0, key_valid}, 4'h0);
        check("rst_down", {3'b0, key_down}, 4'h0);
        check("rst_overrun", {3'b0, overrun}, 4'h0);

        // Hold key 8 (row2/col1) for 10 ticks, then release
        base = valid_rises;
        pressed[2][1] = 1'b1;
        run_periods(10);
        check("s1_code", key_code, 4'h8);
        check("s1_valid", {3'b0, key_valid}, 4'h1);
        check("s1_down", {3'b0, key_down}, 4'h1);
        release_all();
        run_periods(5);
        check("s1_released", {3'b0, key_down}, 4'h0);
        check("s1_one_commit", 4'(valid_rises - base), 4'h1);
        run_period(3);
        check("s1_acked", {3'b0, key_valid}, 4'h0);

        // One-tick glitch on row0
        do_reset();
        pressed[0][0] = 1'b1;
        run_period(-1);
        release_all();
        run_period(-1);
        check("s2_row", row, 4'b1101);
        check("s2_valid", {3'b0, key_valid}, 4'h0);

        // Key 5 not acked, then key D -> overrun
        do_reset();
        pressed[1][1] = 1'b1;
        run_periods(8);
        release_all();
        run_periods(4);
        pressed[3][3] = 1'b1;
        run_periods(8);
        check("s3_code", key_code, 4'hD);
        check("s3_valid", {3'b0, key_valid}, 4'h1);
        check("s3_overrun", {3'b0, overrun}, 4'h1);
        release_all();
        run_periods(4);

        // Ack on the same cycle as the commit of key 3
        do_reset();
        pressed[1][1] = 1'b1;
        run_periods(8);
        release_all();
        run_periods(4);
        pressed[0][2] = 1'b1;
        for (int k = 0; k < 10; k++) run_period(would_commit() ? PER - 1 : -1);
        check("s4_code", key_code, 4'h3);
        check("s4_valid", {3'b0, key_valid}, 4'h1);
        check("s4_overrun", {3'b0, overrun}, 4'h0);
        release_all();
        run_periods(4);

        // Row3 with col0 and col2 low together
        do_reset();
        pressed[3][0] = 1'b1;
        pressed[3][2] = 1'b1;
        run_periods(10);
        check("s5_code", key_code, 4'h0);
        check("s5_valid", {3'b0, key_valid}, 4'h1);
        release_all();
        run_periods(4);

        // Reset during debounce, key still held
        do_reset();
        pressed[2][2] = 1'b1;
        for (int k = 0; k < 8 && m_mode != 1; k++) run_period(-1);
        check("s6_in_debounce", {3'b0, key_down}, 4'h0);
        do_reset();
        check("s6_row", row, 4'b1110);
        check("s6_code", key_code, 4'h0);
        check("s6_valid", {3'b0, key_valid}, 4'h0);
        check("s6_down", {3'b0, key_down}, 4'h0);
        check("s6_overrun", {3'b0, overrun}, 4'h0);
        run_periods(8);
        check("s6_code_again", key_code, 4'h9);
        check("s6_valid_again", {3'b0, key_valid}, 4'h1);
        release_all();
        run_periods(4);

        // Randomised presses, releases and acks against the model
        do_reset();
        for (int it = 0; it < 60; it++) begin
            release_all();
            n = $urandom_range(0, 9);
            if (n < 9) begin
                r1 = $urandom_range(0, 3);
                c1 = $urandom_range(0, 3);
                pressed[r1][c1] = 1'b1;
            end
            if (n >= 7 && n < 9) begin
                r2 = $urandom_range(0, 3);
                c2 = $urandom_range(0, 3);
                pressed[r2][c2] = 1'b1;
            end
            hold = $urandom_range(1, 7);
            for (int h = 0; h < hold; h++) begin
                a = $urandom_range(0, 24);
                run_period(a < PER ? a : -1);
            end
            release_all();
            gap = $urandom_range(1, 5);
            for (int g = 0; g < gap; g++) begin
                a = $urandom_range(0, 24);
                run_period(a < PER ? a : -1);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
